// File: rtl/digimax_pkg.sv
// digimax_pkg: shared types, constants and helpers for the DigiMax mixer.
//   - mix_state_t : sequencer states (IDLE, CH0..CH3, SID, OUT)
//   - DAC_MID / SID_MID : unsigned codes that represent silence
//   - SID_SHIFT / OUT_SHIFT : gain shifts for the SID level and final PCM
//   - dac_to_signed / sid_to_signed : convert raw codes into signed
//     accumulator-width contributions
package digimax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CH0,
    CH1,
    CH2,
    CH3,
    SID,
    OUT
  } mix_state_t;

  localparam logic [7:0] DAC_MID   = 8'h80;
  localparam logic [3:0] SID_MID   = 4'h8;
  localparam int         SID_SHIFT = 4;
  localparam int         OUT_SHIFT = 6;
  // Two DACs (+-128) plus the scaled SID level (-128..+112) need 10 bits.
  localparam int         ACC_W     = 10;

  // Offset-binary DAC code -> signed contribution in -128..+127.
  function automatic logic signed [ACC_W-1:0] dac_to_signed(input logic [7:0] d);
    return $signed({2'b00, d}) - $signed({2'b00, DAC_MID});
  endfunction

  // 4-bit SID digi level -> signed contribution in -128..+112.
  function automatic logic signed [ACC_W-1:0] sid_to_signed(input logic [3:0] lvl);
    return ($signed({6'b000000, lvl}) - $signed({6'b000000, SID_MID})) <<< SID_SHIFT;
  endfunction

endpackage

// File: rtl/digimax_mixer_if.sv
// digimax_mixer_if: bundle between the DigiMax register block / SID digi
// redirect (master side) and the mixer (slave side).
//   enable, dac_0..3, sid_redirect, sid_sample, sid_dm : master -> mixer
//   out_l, out_r, out_valid, overrun                   : mixer -> master
interface digimax_mixer_if #(
  parameter int OUT_W = 16
);
  logic             enable;
  logic [7:0]       dac_0;
  logic [7:0]       dac_1;
  logic [7:0]       dac_2;
  logic [7:0]       dac_3;
  logic             sid_redirect;
  logic             sid_sample;
  logic [3:0]       sid_dm;
  logic [OUT_W-1:0] out_l;
  logic [OUT_W-1:0] out_r;
  logic             out_valid;
  logic             overrun;

  modport master (
    output enable, dac_0, dac_1, dac_2, dac_3, sid_redirect, sid_sample, sid_dm,
    input  out_l, out_r, out_valid, overrun
  );

  modport slave (
    input  enable, dac_0, dac_1, dac_2, dac_3, sid_redirect, sid_sample, sid_dm,
    output out_l, out_r, out_valid, overrun
  );
endinterface

// File: rtl/digimax_tick_gen.sv
// digimax_tick_gen: sample-rate divider.
//   clk, reset : clock and synchronous active-high reset
//   enable     : 1 = count 0..CLK_DIV-1 and wrap; 0 = count held at 0
//   tick       : high for the one cycle in which the count is CLK_DIV-1
module digimax_tick_gen #(
  parameter int CLK_DIV = 672
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    tick    = enable && (count_q == LAST);
    count_d = count_q + 1'b1;
    if (!enable || count_q == LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/digimax_mixer.sv
// digimax_mixer: paces the four DigiMax DAC latches and the redirected SID
// $D418 digi level at CLK_DIV clocks per sample and mixes them, one
// accumulate step per cycle, into signed stereo PCM.
//   clk, reset : clock and synchronous active-high reset
//   bus        : digimax_mixer_if.slave (DAC/SID inputs, PCM outputs,
//                out_valid strobe, sticky overrun flag)
// Left = ch0 + ch2 (+ SID), right = ch1 + ch3 (+ SID).
module digimax_mixer
  import digimax_pkg::*;
#(
  parameter int CLK_DIV = 672,
  parameter int OUT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  digimax_mixer_if.slave   bus
);
  logic tick;

  digimax_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .tick   (tick)
  );

  logic [7:0] dac_in [4];
  assign dac_in[0] = bus.dac_0;
  assign dac_in[1] = bus.dac_1;
  assign dac_in[2] = bus.dac_2;
  assign dac_in[3] = bus.dac_3;

  mix_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [7:0]              dac_q [4];
  logic [7:0]              dac_d [4];
  logic                    redir_q, redir_d;
  logic [3:0]              lvl_q, lvl_d;
  logic [3:0]              sid_lvl_q, sid_lvl_d;
  logic [OUT_W-1:0]        out_l_q, out_l_d, out_r_q, out_r_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic signed [ACC_W-1:0] sid_add, sum_l, sum_r;

  always_comb begin
    state_d     = state_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    dac_d       = dac_q;
    redir_d     = redir_q;
    lvl_d       = lvl_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    sid_add     = '0;
    sum_l       = acc_l_q;
    sum_r       = acc_r_q;
    // The latch follows every $D418 write, whatever the sequencer is doing.
    sid_lvl_d   = bus.sid_sample ? bus.sid_dm : sid_lvl_q;
    // A tick the sequencer cannot accept is lost; remember that it happened.
    overrun_d   = overrun_q | (tick && state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CH0;
          acc_l_d = '0;
          acc_r_d = '0;
          for (int i = 0; i < 4; i++) begin
            dac_d[i] = dac_in[i];
          end
          redir_d = bus.sid_redirect;
          // A $D418 write in the snapshot cycle itself must not be missed.
          lvl_d   = bus.sid_sample ? bus.sid_dm : sid_lvl_q;
        end
      end
      CH0: begin
        acc_l_d = acc_l_q + dac_to_signed(dac_q[0]);
        state_d = CH1;
      end
      CH1: begin
        acc_r_d = acc_r_q + dac_to_signed(dac_q[1]);
        state_d = CH2;
      end
      CH2: begin
        acc_l_d = acc_l_q + dac_to_signed(dac_q[2]);
        state_d = CH3;
      end
      CH3: begin
        acc_r_d = acc_r_q + dac_to_signed(dac_q[3]);
        state_d = SID;
      end
      SID: begin
        // Final sums are loaded straight into the output registers so the
        // strobe is already high during the OUT cycle.
        sid_add     = redir_q ? sid_to_signed(lvl_q) : '0;
        sum_l       = acc_l_q + sid_add;
        sum_r       = acc_r_q + sid_add;
        acc_l_d     = sum_l;
        acc_r_d     = sum_r;
        out_l_d     = {{(OUT_W-ACC_W){sum_l[ACC_W-1]}}, sum_l} << OUT_SHIFT;
        out_r_d     = {{(OUT_W-ACC_W){sum_r[ACC_W-1]}}, sum_r} << OUT_SHIFT;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        dac_q[i] <= DAC_MID;
      end
      redir_q     <= 1'b0;
      lvl_q       <= SID_MID;
      sid_lvl_q   <= SID_MID;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      dac_q       <= dac_d;
      redir_q     <= redir_d;
      lvl_q       <= lvl_d;
      sid_lvl_q   <= sid_lvl_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_digimax_mixer.sv
// Self-checking bench for digimax_mixer: reset state, timing corner cases,
// a table of known mixes and randomized mixes against a plain-arithmetic
// reference model.
module tb_digimax_mixer;
  localparam int CLK_DIV = 16;
  localparam int BOUND   = 4 * CLK_DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  digimax_mixer_if #(.OUT_W(16)) bus ();

  digimax_mixer #(.CLK_DIV(CLK_DIV), .OUT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int lvl_model = 8;

  typedef struct {
    logic [7:0]  d0, d1, d2, d3;
    bit          redir;
    bit          pulse;
    logic [3:0]  dm;
    logic [15:0] el, er;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: mean-centred channel sum (+ scaled SID level) times 64.
  function automatic logic [15:0] pcm(input int a, input int b, input bit redir, input int lvl);
    int v;
    v = (a - 128) + (b - 128) + (redir ? (lvl - 8) * 16 : 0);
    return 16'(v * 64);
  endfunction

  // Advance negedge by negedge until out_valid; n = negedges taken.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      n++;
      if (bus.out_valid === 1'b1) break;
    end
    if (bus.out_valid !== 1'b1) check({name, "_valid_timeout"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic run_txn(input string name, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3, input bit redir,
                         input bit pulse, input logic [3:0] dm,
                         input logic [15:0] el, input logic [15:0] er);
    int n;
    bus.dac_0 = d0; bus.dac_1 = d1; bus.dac_2 = d2; bus.dac_3 = d3;
    bus.sid_redirect = redir;
    if (pulse) begin
      bus.sid_sample = 1'b1;
      bus.sid_dm     = dm;
      @(negedge clk);
      bus.sid_sample = 1'b0;
      bus.sid_dm     = 4'h8;
    end
    wait_valid(name, n);
    check({name, "_l"}, 32'(bus.out_l), 32'(el));
    check({name, "_r"}, 32'(bus.out_r), 32'(er));
    $display("[TB] %s dac=%h %h %h %h redir=%0d l=%h r=%h (exp %h %h)",
             name, d0, d1, d2, d3, redir, bus.out_l, bus.out_r, el, er);
  endtask

  task automatic skip(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int cnt;
    logic [7:0] r0, r1, r2, r3;
    bit rr, rp;
    logic [3:0] rdm;

    vecs[0] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 4'h8, 16'h0000, 16'h0000};
    vecs[1] = '{8'hFF, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b0, 4'h8, 16'h3F80, 16'h0000};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 4'h0, 16'hA000, 16'hA000};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'h8, 16'hC000, 16'hC000};
    vecs[4] = '{8'h80, 8'hFF, 8'h80, 8'h80, 1'b0, 1'b0, 4'h8, 16'h0000, 16'h1FC0};
    vecs[5] = '{8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 4'h8, 16'hE000, 16'hC000};
    vecs[6] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 4'hF, 16'h1C00, 16'h1C00};
    vecs[7] = '{8'h90, 8'h70, 8'h81, 8'h7F, 1'b0, 1'b0, 4'h8, 16'h0440, 16'hFBC0};

    // Reset state.
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.dac_0 = 8'h80; bus.dac_1 = 8'h80; bus.dac_2 = 8'h80; bus.dac_3 = 8'h80;
    bus.sid_redirect = 1'b0; bus.sid_sample = 1'b0; bus.sid_dm = 4'h8;
    skip(3);
    check("rst_out_l", 32'(bus.out_l), 32'd0);
    check("rst_out_r", 32'(bus.out_r), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b0;
    skip(3);
    check("idle_no_valid", 32'(bus.out_valid), 32'd0);

    // Enable -> first tick after CLK_DIV-1 counts, out_valid 6 cycles later.
    bus.enable = 1'b1;
    n = 0; bad = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      n++;
      if (bus.out_valid === 1'b1) break;
      if (bus.out_l !== 16'h0 || bus.out_r !== 16'h0) bad++;
    end
    check("pre_pulse_outputs_zero", 32'(bad), 32'd0);
    check("first_latency", 32'(n), 32'(CLK_DIV + 5));
    check("silence_l", 32'(bus.out_l), 32'd0);
    check("silence_r", 32'(bus.out_r), 32'd0);
    $display("[TB] timing first pulse after %0d cycles", n);
    @(negedge clk);
    check("valid_one_cycle", 32'(bus.out_valid), 32'd0);
    wait_valid("spacing", n);
    check("pulse_spacing", 32'(n + 1), 32'(CLK_DIV));
    $display("[TB] timing pulse spacing %0d cycles", n + 1);

    // Table of known mixes.
    for (int v = 0; v < 8; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3,
              vecs[v].redir, vecs[v].pulse, vecs[v].dm, vecs[v].el, vecs[v].er);
      if (vecs[v].pulse) lvl_model = int'(vecs[v].dm);
    end

    // dac_1 changes during CH0: current sample keeps the snapshot.
    bus.dac_0 = 8'h80; bus.dac_1 = 8'h80; bus.dac_2 = 8'h80; bus.dac_3 = 8'h80;
    bus.sid_redirect = 1'b0;
    skip(CLK_DIV - 5);
    bus.dac_1 = 8'hFF;
    wait_valid("snap_cur", n);
    check("snap_cur_r", 32'(bus.out_r), 32'h0000);
    $display("[TB] snapshot current r=%h", bus.out_r);
    wait_valid("snap_next", n);
    check("snap_next_r", 32'(bus.out_r), 32'h1FC0);
    $display("[TB] snapshot next r=%h", bus.out_r);

    // enable=0 in CH1: sample completes, then silence.
    skip(CLK_DIV - 4);
    bus.enable = 1'b0;
    wait_valid("en_off", n);
    check("en_off_latency", 32'(n), 32'd4);
    check("en_off_r", 32'(bus.out_r), 32'h1FC0);
    cnt = 0;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) cnt++;
    end
    check("en_off_no_pulses", 32'(cnt), 32'd0);
    $display("[TB] enable off: completed after %0d cycles, %0d later pulses", n, cnt);

    // Reset during CH2: aborted sample never emits, outputs cleared.
    bus.dac_0 = 8'hFF; bus.dac_1 = 8'h80; bus.dac_2 = 8'hFF; bus.dac_3 = 8'h80;
    bus.enable = 1'b1;
    skip(CLK_DIV + 2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_l", 32'(bus.out_l), 32'd0);
    check("midrst_r", 32'(bus.out_r), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    lvl_model = 8;
    wait_valid("after_rst", n);
    check("after_rst_latency", 32'(n), 32'(CLK_DIV + 5));
    check("after_rst_l", 32'(bus.out_l), 32'h3F80);
    check("after_rst_r", 32'(bus.out_r), 32'h0000);
    $display("[TB] reset during CH2: next pulse after %0d cycles l=%h r=%h", n, bus.out_l, bus.out_r);

    // Randomized mixes against the reference model.
    for (int t = 0; t < 30; t++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      rr = 1'($urandom); rp = 1'($urandom); rdm = 4'($urandom);
      if (rp) lvl_model = int'(rdm);
      run_txn($sformatf("rnd%0d", t), r0, r1, r2, r3, rr, rp, rdm,
              pcm(int'(r0), int'(r2), rr, lvl_model),
              pcm(int'(r1), int'(r3), rr, lvl_model));
    end

    check("overrun_never", 32'(bus.overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
